// File: rtl/pulse_arbiter_pkg.sv
// Shared definitions for the pulse arbiter: FSM state encoding, the
// width of the shared counter value, and a helper for index widths.
package pulse_arbiter_pkg;

    // Width of the count value returned by the shared counter unit.
    localparam int CNT_W = 6;

    // Arbiter FSM states, kept to a 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } arbState_t;

    // Number of bits needed to hold an index in 0..n-1 (never less than one).
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_arbiter_rr_pick.sv
// Round-robin selector for the pulse arbiter. Purely combinational: given
// the request vector and the index of the last requester served, it returns
// the first active request found after that index, as a one-hot grant and
// as a binary index.
module rr_pick
    import pulse_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan the requesters starting one past the pointer and wrapping around,
    // so the last one served ends up with the lowest priority.
    always_comb begin
        int  cand;
        logic found;
        cand    = 0;
        found   = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                idx_o        = IDX_W'(cand);
                gnt_o[cand]  = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/pulse_arbiter.sv
// Pulse arbiter: shares one pulse/counter unit between N_REQ requesters.
// A requester is picked round-robin, the unit is started with a one-cycle
// ena pulse, the arbiter waits for the completion flag, captures the count
// and acknowledges the requester with a one-cycle done pulse.
//
// Optional feature: define PULSE_ARBITER_TIMEOUT_EN to give up waiting for
// flag after TIMEOUT cycles; the transaction then completes with err raised
// alongside done. Without the macro the wait is unbounded and err is 0.
module pulse_arbiter
    import pulse_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             ena,
    input  logic             flag,
    input  logic [CNT_W-1:0] cnt,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [CNT_W-1:0] last_cnt,
    output logic             busy,
    output logic             err
);

    localparam int IDX_W = idxWidth(N_REQ);

    // The pointer holds the index of the last requester served; starting it
    // at the top index makes requester 0 the first in line after reset.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

    arbState_t        state_q;
    logic             ena_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [CNT_W-1:0] lastCnt_q;
    logic             busy_q;
    logic [IDX_W-1:0] rrPtr_q;
    logic [IDX_W-1:0] selIdx_q;

    logic [N_REQ-1:0] pickGnt;
    logic [IDX_W-1:0] pickIdx;
    logic             pickValid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rrPick (
        .req_i   (req),
        .ptr_i   (rrPtr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

`ifdef PULSE_ARBITER_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    logic [WC_W-1:0] waitCnt_q;
    logic [WC_W-1:0] waitCnt_d;
    logic            err_q;
    logic            waitExpired;

    // Next value of the wait counter and the expiry condition; the counter
    // only advances while the FSM is sitting in WAIT without a flag.
    always_comb begin
        waitCnt_d   = waitCnt_q + WC_W'(1);
        waitExpired = (waitCnt_q == WAIT_LAST);
    end
`endif

    // Main arbiter FSM. All outputs are registered here alongside the state
    // so every output changes exactly on a clock edge. ena, done and err are
    // one-cycle pulses, so they default to 0 on every edge and are only set
    // on the transition that produces them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ena_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            lastCnt_q <= '0;
            busy_q    <= 1'b0;
            rrPtr_q   <= PTR_RESET;
            selIdx_q  <= '0;
`ifdef PULSE_ARBITER_TIMEOUT_EN
            waitCnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            ena_q  <= 1'b0;
            done_q <= '0;
`ifdef PULSE_ARBITER_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pickValid) begin
                        state_q  <= ST_FIRE;
                        ena_q    <= 1'b1;
                        gnt_q    <= pickGnt;
                        selIdx_q <= pickIdx;
                        busy_q   <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_WAIT;
`ifdef PULSE_ARBITER_TIMEOUT_EN
                    waitCnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (flag) begin
                        state_q   <= ST_ACK;
                        lastCnt_q <= cnt;
                        done_q    <= gnt_q;
                    end
`ifdef PULSE_ARBITER_TIMEOUT_EN
                    else if (waitExpired) begin
                        state_q   <= ST_ACK;
                        lastCnt_q <= cnt;
                        done_q    <= gnt_q;
                        err_q     <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
`endif
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    rrPtr_q <= selIdx_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ena      = ena_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign last_cnt = lastCnt_q;
    assign busy     = busy_q;

`ifdef PULSE_ARBITER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed testbench for pulse_arbiter: reset state, round-robin contention,
// single requester, spurious flags, reset during WAIT, request drop and,
// when PULSE_ARBITER_TIMEOUT_EN is defined, the WAIT timeout.
module tb_pulse_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 63;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ena;
    logic       flag;
    logic [5:0] cnt;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [5:0] last_cnt;
    logic       busy;
    logic       err;

    int assertCount;
    int failCount;
    int enaCount;

    pulse_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ena      (ena),
        .flag     (flag),
        .cnt      (cnt),
        .gnt      (gnt),
        .done     (done),
        .last_cnt (last_cnt),
        .busy     (busy),
        .err      (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count ena pulses half a cycle after they are launched.
    always @(negedge clk) begin
        if (ena === 1'b1) enaCount++;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one arbitration cycle with the caller's req already driven:
    // wait (bounded) for ena, check the grant, optionally drop req during
    // WAIT, raise flag after flagDelay WAIT cycles and check the completion.
    task automatic applyStimulus(input string tag, input logic [3:0] expGnt,
                                 input logic [5:0] cntVal, input int flagDelay,
                                 input bit dropReq);
        int  waited;
        bit  seen;
        waited = 0;
        seen   = 0;
        while (!seen && waited < 8) begin
            tick();
            waited++;
            if (ena === 1'b1) seen = 1;
        end
        if (!seen) begin
            checkOutput({tag, "_ena_seen"}, 0, 1);
            return;
        end
        checkOutput({tag, "_ena_latency"}, waited, 1);
        checkOutput({tag, "_gnt"}, gnt, expGnt);
        checkOutput({tag, "_busy"}, busy, 1);
        tick();
        checkOutput({tag, "_ena_one_cycle"}, ena, 0);
        if (dropReq) req = 4'b0000;
        repeat (flagDelay) tick();
        checkOutput({tag, "_no_early_done"}, done, 0);
        flag = 1'b1;
        cnt  = cntVal;
        tick();
        flag = 1'b0;
        checkOutput({tag, "_done"}, done, expGnt);
        checkOutput({tag, "_last_cnt"}, last_cnt, cntVal);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_gnt_in_ack"}, gnt, expGnt);
        tick();
        checkOutput({tag, "_done_one_cycle"}, done, 0);
        checkOutput({tag, "_gnt_cleared"}, gnt, 0);
    endtask

    initial begin
        int enaBefore;
        int waitCycles;
        assertCount = 0;
        failCount   = 0;
        enaCount    = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        flag = 1'b0;
        cnt  = 6'd0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_ena", ena, 0);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_last_cnt", last_cnt, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_no_ena", ena, 0);

        // Contention: all four requesting, served 0,1,2,3 back to back.
        enaBefore = enaCount;
        req = 4'b1111;
        applyStimulus("cont0", 4'b0001, 6'd3, 2, 0);
        applyStimulus("cont1", 4'b0010, 6'd4, 0, 0);
        applyStimulus("cont2", 4'b0100, 6'd5, 1, 0);
        applyStimulus("cont3", 4'b1000, 6'd6, 3, 0);
        req = 4'b0000;
        tick();
        tick();
        checkOutput("cont_ena_pulses", enaCount - enaBefore, 4);
        checkOutput("cont_idle_busy", busy, 0);

        // Single requester; flag returns 20 cycles after ena.
        enaBefore = enaCount;
        req = 4'b0010;
        applyStimulus("single", 4'b0010, 6'd20, 19, 0);
        req = 4'b0000;
        tick();
        checkOutput("single_ena_pulses", enaCount - enaBefore, 1);

        // Spurious flag in IDLE and in FIRE must be ignored.
        flag = 1'b1;
        cnt  = 6'd50;
        tick();
        tick();
        checkOutput("spur_idle_busy", busy, 0);
        checkOutput("spur_idle_done", done, 0);
        req = 4'b0100;
        tick();
        checkOutput("spur_fire_ena", ena, 1);
        tick();
        checkOutput("spur_fire_done", done, 0);
        checkOutput("spur_fire_gnt", gnt, 4'b0100);
        flag = 1'b0;
        repeat (3) tick();
        checkOutput("spur_wait_done", done, 0);
        checkOutput("spur_wait_busy", busy, 1);
        flag = 1'b1;
        cnt  = 6'd7;
        tick();
        flag = 1'b0;
        req  = 4'b0000;
        checkOutput("spur_done", done, 4'b0100);
        checkOutput("spur_last_cnt", last_cnt, 7);
        tick();
        tick();

        // Reset in the middle of WAIT aborts the transaction.
        req = 4'b0001;
        tick();
        checkOutput("rstw_ena", ena, 1);
        checkOutput("rstw_gnt", gnt, 4'b0001);
        tick();
        tick();
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        checkOutput("rstw_busy", busy, 0);
        checkOutput("rstw_gnt_clear", gnt, 0);
        flag = 1'b1;
        cnt  = 6'd33;
        tick();
        flag = 1'b0;
        checkOutput("rstw_no_done", done, 0);
        checkOutput("rstw_still_idle", busy, 0);
        checkOutput("rstw_last_cnt", last_cnt, 0);
        tick();
        checkOutput("rstw_no_done_late", done, 0);
        req = 4'b0001;
        applyStimulus("rstw_restart", 4'b0001, 6'd5, 2, 0);
        req = 4'b0000;
        tick();

        // Granted request drops during WAIT; completion still happens and
        // the pointer moves past it (next pick from 0110 is requester 2).
        req = 4'b0110;
        applyStimulus("drop", 4'b0010, 6'd41, 2, 1);
        req = 4'b0110;
        applyStimulus("drop_next", 4'b0100, 6'd42, 1, 0);
        req = 4'b0000;
        tick();

`ifdef PULSE_ARBITER_TIMEOUT_EN
        // Timeout: flag never comes; done and err land on WAIT cycle 64.
        req = 4'b0001;
        tick();
        checkOutput("tmo_ena", ena, 1);
        tick();
        waitCycles = 1;
        while (done === 4'b0000 && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
        checkOutput("tmo_cycles", waitCycles, 64);
        checkOutput("tmo_done", done, 4'b0001);
        checkOutput("tmo_err", err, 1);
        req = 4'b0000;
        tick();
        checkOutput("tmo_err_one_cycle", err, 0);
        tick();
`else
        waitCycles = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
